// File: rtl/eth_stream_reader.sv
// Memory-to-host read path: on opcode 8'h02, fetches a fixed burst from the selected
// memory bank and streams it out on AXI4-Stream, with credit-based read issue.
//
// state  | meaning
// IDLE   | waiting for a read-burst opcode
// STREAM | issuing reads and emitting beats until the TLAST beat is accepted
// DONE   | burst complete, done held until the host drops the opcode
module eth_stream_reader #(
  parameter int DATA_W     = 64,
  parameter int MEM_W      = 60,
  parameter int ADDR_W     = 11,
  parameter int BURST_LEN  = 128,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  input  logic [31:0]           Command0,
  output logic [31:0]           Status0,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [2:0]            mem_proc_sel,
  output logic [3:0]            mem_top_sel,
  input  logic [MEM_W-1:0]      mem_rdata,
  output logic                  M00_AXIS_tvalid,
  output logic [DATA_W-1:0]     M00_AXIS_tdata,
  output logic [DATA_W/8-1:0]   M00_AXIS_tstrb,
  output logic                  M00_AXIS_tlast,
  input  logic                  M00_AXIS_tready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t              state;
  logic [MEM_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [7:0]          fifo_cnt;
  logic [7:0]          in_flight;
  logic [RD_LAT-1:0]   rd_pipe;
  logic [11:0]         issue_cnt;
  logic [11:0]         beat_cnt;
  logic                busy, done;

  logic                cmd_rd, pop, out_free, push, fifo_rd, fifo_wr, issue, issue_any, next_last;
  logic [7:0]          credit;
  logic                unused_cmd;

  assign unused_cmd = ^{Command0[23], Command0[15:ADDR_W]};
  assign Status0    = {busy, done, 18'b0, beat_cnt};

  always_comb begin
    cmd_rd    = (Command0[31:24] == 8'h02);
    pop       = M00_AXIS_tvalid & M00_AXIS_tready;
    out_free  = ~M00_AXIS_tvalid | pop;
    push      = rd_pipe[RD_LAT-1];
    fifo_rd   = out_free && (fifo_cnt != 8'd0);
    fifo_wr   = push && !(out_free && (fifo_cnt == 8'd0));
    // The output register counts as one storage slot, so credit covers FIFO + output + in-flight.
    credit    = fifo_cnt + 8'(M00_AXIS_tvalid) + in_flight - 8'(pop);
    issue     = (state == STREAM) && (issue_cnt < 12'(BURST_LEN)) && (credit < 8'(FIFO_DEPTH));
    issue_any = issue || ((state == IDLE) && cmd_rd);
    next_last = ((beat_cnt + 12'(pop)) == 12'(BURST_LEN - 1));
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      in_flight       <= '0;
      rd_pipe         <= '0;
      issue_cnt       <= '0;
      beat_cnt        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      mem_rd_en       <= 1'b0;
      mem_addr        <= '0;
      mem_proc_sel    <= '0;
      mem_top_sel     <= '0;
      M00_AXIS_tvalid <= 1'b0;
      M00_AXIS_tdata  <= '0;
      M00_AXIS_tstrb  <= '0;
      M00_AXIS_tlast  <= 1'b0;
    end else begin
      rd_pipe   <= RD_LAT'({rd_pipe, mem_rd_en});
      mem_rd_en <= issue_any;
      in_flight <= in_flight + 8'(issue_any) - 8'(push);
      fifo_cnt  <= fifo_cnt + 8'(fifo_wr) - 8'(fifo_rd);
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);

      if (out_free) begin
        if (fifo_cnt != 8'd0) begin
          M00_AXIS_tvalid <= 1'b1;
          M00_AXIS_tdata  <= DATA_W'(fifo_mem[rd_ptr]);
          M00_AXIS_tstrb  <= '1;
          M00_AXIS_tlast  <= next_last;
        end else if (push) begin
          M00_AXIS_tvalid <= 1'b1;
          M00_AXIS_tdata  <= DATA_W'(mem_rdata);
          M00_AXIS_tstrb  <= '1;
          M00_AXIS_tlast  <= next_last;
        end else begin
          M00_AXIS_tvalid <= 1'b0;
          M00_AXIS_tstrb  <= '0;
          M00_AXIS_tlast  <= 1'b0;
        end
      end

      if (pop) beat_cnt <= beat_cnt + 12'd1;

      case (state)
        IDLE: begin
          if (cmd_rd) begin
            state        <= STREAM;
            mem_proc_sel <= Command0[22:20];
            mem_top_sel  <= Command0[19:16];
            mem_addr     <= Command0[ADDR_W-1:0];
            issue_cnt    <= 12'd1;
            beat_cnt     <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        STREAM: begin
          if (issue) begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            issue_cnt <= issue_cnt + 12'd1;
          end
          if (pop && M00_AXIS_tlast) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!cmd_rd) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_stream_reader.sv
// Directed bench for eth_stream_reader: burst contents, latency, wrap, backpressure,
// re-arm, mid-burst reset and command-change behaviour against hand-derived expectations.
module tb_eth_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Command0;
  logic [31:0] Status0;
  logic        mem_rd_en;
  logic [10:0] mem_addr;
  logic [2:0]  mem_proc_sel;
  logic [3:0]  mem_top_sel;
  logic [59:0] mem_rdata = '0;
  logic        tvalid;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic        tlast;
  logic        tready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  eth_stream_reader dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .Command0         (Command0),
    .Status0          (Status0),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .mem_proc_sel     (mem_proc_sel),
    .mem_top_sel      (mem_top_sel),
    .mem_rdata        (mem_rdata),
    .M00_AXIS_tvalid  (tvalid),
    .M00_AXIS_tdata   (tdata),
    .M00_AXIS_tstrb   (tstrb),
    .M00_AXIS_tlast   (tlast),
    .M00_AXIS_tready  (tready)
  );

  // Two-stage memory: data for a read strobed in cycle c is presented in cycle c+2.
  logic [59:0] m_s1 = '0;
  always @(posedge clk) begin
    if (mem_rd_en) m_s1 <= 60'({mem_proc_sel, mem_top_sel, mem_addr});
    else           m_s1 <= '1;
    mem_rdata <= m_s1;
  end

  function automatic logic [31:0] mk_cmd(input logic [7:0] op, input logic [2:0] p,
                                         input logic [3:0] t, input logic [10:0] a);
    return {op, 1'b0, p, t, 5'b0, a};
  endfunction

  function automatic logic [63:0] exp_word(input logic [2:0] p, input logic [3:0] t, input int a);
    logic [10:0] aw;
    aw = 11'(a % 2048);
    return 64'({p, t, aw});
  endfunction

  logic [63:0] c_data  [256];
  logic        c_lastb [256];
  int c_nbeats, c_timeout, c_first_rd, c_first_valid, c_last_iter;
  int c_stab_err, c_strb_err, c_credit_max, c_issued;

  // Drives tready and records accepted beats plus protocol statistics; iteration 0 is
  // the first cycle after the edge that samples the command.
  task automatic collect(input int ready_mode, input int stop_n, input int chg_at,
                         input logic [31:0] chg_cmd, input int budget);
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    bit          fin;
    for (int i = 0; i < 256; i++) begin c_data[i] = 'x; c_lastb[i] = 1'bx; end
    c_nbeats = 0; c_timeout = 0; c_first_rd = -1; c_first_valid = -1; c_last_iter = -1;
    c_stab_err = 0; c_strb_err = 0; c_credit_max = 0; c_issued = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; fin = 1'b0;
    for (int k = 0; k < budget && !fin; k++) begin
      @(negedge clk);
      if (k == chg_at) Command0 = chg_cmd;
      if (ready_mode == 0) tready = 1'b1;
      else tready = (k >= 60 && k < 80) ? 1'b0 : ($urandom_range(0, 99) < 30);
      if (mem_rd_en) begin
        if (c_first_rd < 0) c_first_rd = k;
        c_issued++;
      end
      if (c_issued - c_nbeats > c_credit_max) c_credit_max = c_issued - c_nbeats;
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) c_stab_err++;
      if (tvalid && tstrb !== 8'hFF) c_strb_err++;
      if (tvalid && c_first_valid < 0) c_first_valid = k + 1;
      if (tvalid && tready) begin
        if (c_nbeats < 256) begin c_data[c_nbeats] = tdata; c_lastb[c_nbeats] = tlast; end
        c_nbeats++;
        if (tlast || c_nbeats == stop_n) begin fin = 1'b1; c_last_iter = k; end
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
    if (!fin) c_timeout = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Command0 = '0; tready = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++; if ({tvalid, tlast, mem_rd_en} !== 3'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 000", {tvalid, tlast, mem_rd_en}); end
    n_tests++; if (tdata !== 64'h0 || tstrb !== 8'h0) begin n_fail++;
      $display("FAIL reset_data: got %h/%h want 0/0", tdata, tstrb); end
    n_tests++; if ({mem_addr, mem_proc_sel, mem_top_sel} !== 18'h0) begin n_fail++;
      $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_proc_sel, mem_top_sel}); end
    n_tests++; if (Status0 !== 32'h0) begin n_fail++;
      $display("FAIL reset_status: got %h want 0", Status0); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (mem_rd_en !== 1'b0 || Status0 !== 32'h0) begin n_fail++;
      $display("FAIL reset_idle: got rd=%b st=%h want 0/0", mem_rd_en, Status0); end
  endtask

  task automatic test_ignored_opcode();
    logic [7:0] ops [2];
    int act;
    ops[0] = 8'h01; ops[1] = 8'h20;
    for (int j = 0; j < 2; j++) begin
      act = 0;
      Command0 = mk_cmd(ops[j], 3'd3, 4'd4, 11'd256);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (mem_rd_en || tvalid) act++;
      end
      n_tests++; if (act != 0) begin n_fail++;
        $display("FAIL ignored_op_%h: got %0d active cycles want 0", ops[j], act); end
      n_tests++; if (Status0 !== 32'h0) begin n_fail++;
        $display("FAIL ignored_op_%h_status: got %h want 0", ops[j], Status0); end
    end
    Command0 = '0;
    @(negedge clk);
  endtask

  task automatic test_basic_burst();
    @(negedge clk);
    Command0 = mk_cmd(8'h02, 3'd3, 4'd4, 11'd256);
    collect(0, 0, -1, 32'h0, 400);
    n_tests++; if (c_timeout != 0 || c_nbeats != 128) begin n_fail++;
      $display("FAIL basic_count: got %0d beats timeout=%0d want 128", c_nbeats, c_timeout); end
    for (int k = 0; k < 128; k++) begin
      n_tests++; if (c_data[k] !== exp_word(3'd3, 4'd4, 256 + k)) begin n_fail++;
        $display("FAIL basic_beat%0d: got %h want %h", k, c_data[k], exp_word(3'd3, 4'd4, 256 + k)); end
      n_tests++; if (c_lastb[k] !== (k == 127)) begin n_fail++;
        $display("FAIL basic_tlast%0d: got %b want %b", k, c_lastb[k], (k == 127)); end
    end
    n_tests++; if (c_first_rd != 0) begin n_fail++;
      $display("FAIL basic_first_rd: got %0d want 0", c_first_rd); end
    n_tests++; if (c_first_valid != 4) begin n_fail++;
      $display("FAIL basic_first_valid: got %0d want 4", c_first_valid); end
    n_tests++; if (c_last_iter != 130) begin n_fail++;
      $display("FAIL basic_last_cycle: got %0d want 130", c_last_iter); end
    n_tests++; if (c_strb_err != 0) begin n_fail++;
      $display("FAIL basic_tstrb: got %0d errors want 0", c_strb_err); end
    @(negedge clk);
    n_tests++; if (Status0 !== 32'h4000_0080) begin n_fail++;
      $display("FAIL basic_status: got %h want 40000080", Status0); end
    n_tests++; if (mem_proc_sel !== 3'd3 || mem_top_sel !== 4'd4) begin n_fail++;
      $display("FAIL basic_sel: got %0d/%0d want 3/4", mem_proc_sel, mem_top_sel); end
    Command0 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    Command0 = mk_cmd(8'h02, 3'd1, 4'd2, 11'd1984);
    collect(0, 0, -1, 32'h0, 400);
    n_tests++; if (c_timeout != 0 || c_nbeats != 128) begin n_fail++;
      $display("FAIL wrap_count: got %0d beats timeout=%0d want 128", c_nbeats, c_timeout); end
    for (int k = 0; k < 128; k++) begin
      n_tests++; if (c_data[k] !== exp_word(3'd1, 4'd2, 1984 + k)) begin n_fail++;
        $display("FAIL wrap_beat%0d: got %h want %h", k, c_data[k], exp_word(3'd1, 4'd2, 1984 + k)); end
    end
    Command0 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    Command0 = mk_cmd(8'h02, 3'd2, 4'd11, 11'd100);
    collect(1, 0, -1, 32'h0, 4000);
    tready = 1'b1;
    n_tests++; if (c_timeout != 0 || c_nbeats != 128) begin n_fail++;
      $display("FAIL bp_count: got %0d beats timeout=%0d want 128", c_nbeats, c_timeout); end
    for (int k = 0; k < 128; k++) begin
      n_tests++; if (c_data[k] !== exp_word(3'd2, 4'd11, 100 + k)) begin n_fail++;
        $display("FAIL bp_beat%0d: got %h want %h", k, c_data[k], exp_word(3'd2, 4'd11, 100 + k)); end
      n_tests++; if (c_lastb[k] !== (k == 127)) begin n_fail++;
        $display("FAIL bp_tlast%0d: got %b want %b", k, c_lastb[k], (k == 127)); end
    end
    n_tests++; if (c_stab_err != 0) begin n_fail++;
      $display("FAIL bp_stable: got %0d unstable stalls want 0", c_stab_err); end
    n_tests++; if (c_credit_max > 4) begin n_fail++;
      $display("FAIL bp_credit: got %0d outstanding want <= 4", c_credit_max); end
    n_tests++; if (c_issued != 128) begin n_fail++;
      $display("FAIL bp_issued: got %0d reads want 128", c_issued); end
    n_tests++; if (c_strb_err != 0) begin n_fail++;
      $display("FAIL bp_tstrb: got %0d errors want 0", c_strb_err); end
    Command0 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rearm();
    int act;
    @(negedge clk);
    Command0 = mk_cmd(8'h02, 3'd6, 4'd7, 11'd500);
    collect(0, 0, -1, 32'h0, 400);
    n_tests++; if (c_timeout != 0 || c_nbeats != 128) begin n_fail++;
      $display("FAIL rearm_first: got %0d beats timeout=%0d want 128", c_nbeats, c_timeout); end
    act = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (mem_rd_en || tvalid) act++;
    end
    n_tests++; if (act != 0) begin n_fail++;
      $display("FAIL rearm_hold: got %0d active cycles want 0", act); end
    n_tests++; if (Status0 !== 32'h4000_0080) begin n_fail++;
      $display("FAIL rearm_hold_status: got %h want 40000080", Status0); end
    Command0 = '0;
    @(negedge clk);
    n_tests++; if (Status0[31:30] !== 2'b00) begin n_fail++;
      $display("FAIL rearm_clear: got busy/done %b want 00", Status0[31:30]); end
    @(negedge clk);
    Command0 = mk_cmd(8'h02, 3'd6, 4'd7, 11'd10);
    collect(0, 0, -1, 32'h0, 400);
    n_tests++; if (c_timeout != 0 || c_nbeats != 128) begin n_fail++;
      $display("FAIL rearm_second: got %0d beats timeout=%0d want 128", c_nbeats, c_timeout); end
    for (int k = 0; k < 128; k++) begin
      n_tests++; if (c_data[k] !== exp_word(3'd6, 4'd7, 10 + k)) begin n_fail++;
        $display("FAIL rearm_beat%0d: got %h want %h", k, c_data[k], exp_word(3'd6, 4'd7, 10 + k)); end
    end
    Command0 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int act;
    @(negedge clk);
    Command0 = mk_cmd(8'h02, 3'd4, 4'd5, 11'd300);
    collect(0, 41, -1, 32'h0, 400);
    n_tests++; if (c_timeout != 0 || c_data[40] !== exp_word(3'd4, 4'd5, 340)) begin n_fail++;
      $display("FAIL rmid_pre: got %h timeout=%0d want %h", c_data[40], c_timeout, exp_word(3'd4, 4'd5, 340)); end
    @(negedge clk);
    rst_n = 1'b0; Command0 = '0; tready = 1'b0;
    @(negedge clk);
    n_tests++; if ({tvalid, tlast, mem_rd_en, tdata, tstrb} !== 75'h0) begin n_fail++;
      $display("FAIL rmid_outputs: got v=%b l=%b rd=%b d=%h s=%h want 0", tvalid, tlast, mem_rd_en, tdata, tstrb); end
    n_tests++; if ({mem_addr, mem_proc_sel, mem_top_sel, Status0} !== 50'h0) begin n_fail++;
      $display("FAIL rmid_mem_status: got a=%h p=%h t=%h st=%h want 0", mem_addr, mem_proc_sel, mem_top_sel, Status0); end
    rst_n = 1'b1; tready = 1'b1;
    act = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_rd_en || tvalid) act++;
    end
    n_tests++; if (act != 0) begin n_fail++;
      $display("FAIL rmid_quiet: got %0d active cycles want 0", act); end
    Command0 = mk_cmd(8'h02, 3'd0, 4'd15, 11'd600);
    collect(0, 0, -1, 32'h0, 400);
    n_tests++; if (c_timeout != 0 || c_nbeats != 128) begin n_fail++;
      $display("FAIL rmid_fresh: got %0d beats timeout=%0d want 128", c_nbeats, c_timeout); end
    for (int k = 0; k < 128; k++) begin
      n_tests++; if (c_data[k] !== exp_word(3'd0, 4'd15, 600 + k)) begin n_fail++;
        $display("FAIL rmid_beat%0d: got %h want %h", k, c_data[k], exp_word(3'd0, 4'd15, 600 + k)); end
    end
    Command0 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cmd_change();
    @(negedge clk);
    Command0 = mk_cmd(8'h02, 3'd5, 4'd9, 11'd1000);
    collect(0, 0, 20, mk_cmd(8'h02, 3'd2, 4'd1, 11'd50), 400);
    n_tests++; if (c_timeout != 0 || c_nbeats != 128) begin n_fail++;
      $display("FAIL chg_count: got %0d beats timeout=%0d want 128", c_nbeats, c_timeout); end
    for (int k = 0; k < 128; k++) begin
      n_tests++; if (c_data[k] !== exp_word(3'd5, 4'd9, 1000 + k)) begin n_fail++;
        $display("FAIL chg_beat%0d: got %h want %h", k, c_data[k], exp_word(3'd5, 4'd9, 1000 + k)); end
    end
    n_tests++; if (mem_proc_sel !== 3'd5 || mem_top_sel !== 4'd9) begin n_fail++;
      $display("FAIL chg_sel: got %0d/%0d want 5/9", mem_proc_sel, mem_top_sel); end
    Command0 = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ignored_opcode();
    test_basic_burst();
    test_wrap();
    test_backpressure();
    test_rearm();
    test_reset_mid();
    test_cmd_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
